and_if: RTL and testbench
=========================

AND_IF -- requirements
Module: and_if

Interface
REQ-001 Parameter WIDTH SHALL be: default 4; operand and result bit width; legal range 1..64.
REQ-002 Port clk SHALL be: input, 1 bit; single clock, all state updates on its rising edge.
REQ-003 Port rst SHALL be: input, 1 bit; reset, synchronous, active-high.
REQ-004 Port a SHALL be: input, WIDTH bits; first operand.
REQ-005 Port b SHALL be: input, WIDTH bits; second operand.
REQ-006 Port in_valid SHALL be: input, 1 bit; a/b hold a valid operand pair.
REQ-007 Port in_ready SHALL be: output, 1 bit; block can accept a pair this cycle.
REQ-008 Port y SHALL be: output, WIDTH bits; bitwise AND result.
REQ-009 Port y_zero SHALL be: output, 1 bit; high when y is all zeros.
REQ-010 Port out_valid SHALL be: output, 1 bit; y/y_zero hold a valid result.
REQ-011 Port out_ready SHALL be: input, 1 bit; downstream accepts the result this cycle.

Function
REQ-012 Each result SHALL be y[i] = a[i] & b[i] for every bit i; no carries, no cross-bit interaction.
REQ-013 Input transfer SHALL occur on a rising clk edge with in_valid & in_ready; output transfer SHALL occur on a rising clk edge with out_valid & out_ready.
REQ-014 The datapath SHALL be a 2-entry FIFO (output register plus skid register); latency SHALL be exactly 1 cycle from input transfer to out_valid when the FIFO is empty.
REQ-015 in_ready SHALL be a registered signal: high when fewer than 2 entries are held, low when 2 entries are held; it SHALL NOT depend combinationally on out_ready.
REQ-016 Results SHALL leave in the same order they were accepted; no result SHALL be dropped or duplicated.
REQ-017 When the FIFO is full, in_valid SHALL be ignored (no transfer); a/b SHALL NOT affect state.
REQ-018 A simultaneous input and output transfer SHALL keep occupancy unchanged; with one entry held, the new result SHALL appear on y the next cycle, with no bubble.
REQ-019 While out_valid is high and out_ready is low, y, y_zero and out_valid SHALL remain stable.
REQ-020 y_zero SHALL be computed when the pair is accepted and stored alongside y.
REQ-021 When out_valid is low, y and y_zero SHALL be 0.

Reset
REQ-022 On a clock edge with rst high: occupancy SHALL be set to 0, out_valid to 0, y to 0, y_zero to 0, and in_ready to 1 on the following cycle.
REQ-023 Reset SHALL take priority over any simultaneous transfer; in-flight results SHALL be discarded.
REQ-024 In the first cycle after rst is deasserted, the block SHALL be able to accept a pair.

Configuration
REQ-025 Macro AND_IF_PARITY_EN defined SHALL add output port y_par (1 bit) = XOR-reduction of y, stored and qualified like y_zero, and 0 when out_valid is low or after reset.
REQ-026 Macro AND_IF_PARITY_EN undefined SHALL omit port y_par and its logic entirely; all other behaviour SHALL be identical.

Verification
REQ-027 Basic: WIDTH=4, out_ready=1, a=0100, b=1100 -> one cycle later out_valid=1, y=0100, y_zero=0.
REQ-028 Streaming: back-to-back pairs (0100,1100) then (0110,1101), out_ready=1 -> y=0100 in two consecutive cycles, in_ready stays 1.
REQ-029 Zero flag: a=1010, b=0101 -> y=0000, y_zero=1; with AND_IF_PARITY_EN, a=1111, b=0111 -> y_par=1.
REQ-030 Backpressure: out_ready=0, three pairs offered -> two accepted, in_ready low after the second; y held stable; release out_ready -> both results out in order, third accepted afterwards.
REQ-031 Reset mid-operation: FIFO full, rst=1 for one cycle -> out_valid=0, y=0000, in_ready=1 next cycle; no stale result appears.

Source files
------------

// File: rtl/and_if.sv
// and_if: registered bitwise AND of two WIDTH-bit operands.
// The result path is a 2-entry FIFO (output register plus skid register)
// with valid/ready handshakes on both sides.
// Optional feature: define AND_IF_PARITY_EN to add output y_par, the
// XOR-reduction of y, stored and qualified alongside y_zero.
module and_if #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             out_valid,
    input  logic             out_ready
`ifdef AND_IF_PARITY_EN
    ,
    output logic             y_par
`endif
);

    // Each stored entry is {parity (optional), zero flag, result}.
`ifdef AND_IF_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int ENTRY_W = WIDTH + 1 + PAR_W;

    logic [ENTRY_W-1:0] head_q, head_d;   // entry presented on y
    logic [ENTRY_W-1:0] skid_q, skid_d;   // second entry, held under backpressure
    logic [1:0]         count_q, count_d; // entries held: 0, 1 or 2
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   and_res;
    logic [ENTRY_W-1:0] new_entry;
    logic               push;
    logic               pop;

    // Build the entry for the incoming pair; flags are computed at accept time.
    always_comb begin
        and_res = a & b;
`ifdef AND_IF_PARITY_EN
        new_entry = {^and_res, ~|and_res, and_res};
`else
        new_entry = {~|and_res, and_res};
`endif
    end

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // Next-state for the two FIFO slots, occupancy and handshake flags.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (which would infer a latch).
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = new_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    // Pass-through: the new result replaces the departing one, no bubble.
                    head_d = new_entry;
                end else if (push) begin
                    skid_d  = new_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    // Empty output reads as zero.
                    head_d  = '0;
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    head_d  = skid_q;
                    skid_d  = '0;
                    count_d = 2'd1;
                end
            end
            default: begin
                head_d  = '0;
                skid_d  = '0;
                count_d = 2'd0;
            end
        endcase
        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    // State registers with synchronous reset that overrides any transfer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            head_q      <= '0;
            skid_q      <= '0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            skid_q      <= skid_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = head_q[WIDTH-1:0];
    assign y_zero    = head_q[WIDTH];
`ifdef AND_IF_PARITY_EN
    assign y_par     = head_q[WIDTH+1];
`endif

endmodule

// File: tb/tb_and_if.sv
// Self-checking bench for and_if: a queue-based reference model compared on
// every falling edge, directed scenarios with literal expectations, then a
// randomized phase with occasional resets.
module tb_and_if;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic         in_valid, out_ready;
    logic         in_ready, y_zero, out_valid;
    logic [W-1:0] y;
`ifdef AND_IF_PARITY_EN
    logic         y_par;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    and_if #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .y_zero    (y_zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef AND_IF_PARITY_EN
        ,
        .y_par     (y_par)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a bounded queue of results, capacity 2.
    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         p;
    } ent_t;

    ent_t model_q[$];

    always @(posedge clk) begin
        int   sz;
        ent_t e;
        sz = model_q.size();
        if (rst) begin
            model_q.delete();
        end else begin
            if (sz > 0 && out_ready) void'(model_q.pop_front());
            if (sz < 2 && in_valid) begin
                e.r = a & b;
                e.z = ((a & b) == 0);
                e.p = ^(a & b);
                model_q.push_back(e);
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (model_q.size() > 0) begin
                check("m_out_valid", 64'(out_valid), 64'(1));
                check("m_y", 64'(y), 64'(model_q[0].r));
                check("m_y_zero", 64'(y_zero), 64'(model_q[0].z));
`ifdef AND_IF_PARITY_EN
                check("m_y_par", 64'(y_par), 64'(model_q[0].p));
`endif
            end else begin
                check("m_out_valid", 64'(out_valid), 64'(0));
                check("m_y", 64'(y), 64'(0));
                check("m_y_zero", 64'(y_zero), 64'(0));
`ifdef AND_IF_PARITY_EN
                check("m_y_par", 64'(y_par), 64'(0));
`endif
            end
            check("m_in_ready", 64'(in_ready), 64'(model_q.size() < 2));
        end
    end

    task automatic drive(input logic r, input logic iv, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ordy);
        rst       = r;
        in_valid  = iv;
        a         = av;
        b         = bv;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, '0, 1'b1);
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_y", 64'(y), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Basic transfer, one cycle latency; ready right after reset.
        drive(1'b0, 1'b1, 4'b0100, 4'b1100, 1'b1);
        check("first_in_ready", 64'(in_ready), 64'(1));
        tick();
        check("basic_valid", 64'(out_valid), 64'(1));
        check("basic_y", 64'(y), 64'(4'b0100));
        check("basic_zero", 64'(y_zero), 64'(0));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        check("basic_drain", 64'(out_valid), 64'(0));

        // Streaming back-to-back.
        drive(1'b0, 1'b1, 4'b0100, 4'b1100, 1'b1);
        tick();
        check("stream1_y", 64'(y), 64'(4'b0100));
        check("stream1_rdy", 64'(in_ready), 64'(1));
        drive(1'b0, 1'b1, 4'b0110, 4'b1101, 1'b1);
        tick();
        check("stream2_valid", 64'(out_valid), 64'(1));
        check("stream2_y", 64'(y), 64'(4'b0100));
        check("stream2_rdy", 64'(in_ready), 64'(1));

        // Zero flag (and parity when enabled).
        drive(1'b0, 1'b1, 4'b1010, 4'b0101, 1'b1);
        tick();
        check("zero_y", 64'(y), 64'(0));
        check("zero_flag", 64'(y_zero), 64'(1));
`ifdef AND_IF_PARITY_EN
        drive(1'b0, 1'b1, 4'b1111, 4'b0111, 1'b1);
        tick();
        check("par_y", 64'(y), 64'(4'b0111));
        check("par_bit", 64'(y_par), 64'(1));
`endif
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        tick();

        // Backpressure: three offered, two held, third waits.
        drive(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0);
        tick();
        check("bp1_y", 64'(y), 64'(4'b0001));
        check("bp1_rdy", 64'(in_ready), 64'(1));
        drive(1'b0, 1'b1, 4'b0110, 4'b0111, 1'b0);
        tick();
        check("bp2_rdy", 64'(in_ready), 64'(0));
        check("bp2_y", 64'(y), 64'(4'b0001));
        drive(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0);
        tick();
        check("bp3_rdy", 64'(in_ready), 64'(0));
        check("bp3_y", 64'(y), 64'(4'b0001));
        tick();
        check("bp3_hold_y", 64'(y), 64'(4'b0001));
        check("bp3_hold_valid", 64'(out_valid), 64'(1));
        drive(1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1);
        tick();
        check("bp_rel1_y", 64'(y), 64'(4'b0110));
        check("bp_rel1_rdy", 64'(in_ready), 64'(1));
        tick();
        check("bp_rel2_y", 64'(y), 64'(4'b1000));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        check("bp_empty", 64'(out_valid), 64'(0));

        // Reset while full, with a transfer also requested.
        drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);
        tick();
        drive(1'b0, 1'b1, 4'b0111, 4'b1111, 1'b0);
        tick();
        check("full_rdy", 64'(in_ready), 64'(0));
        drive(1'b1, 1'b1, 4'b0011, 4'b0011, 1'b1);
        tick();
        check("rstmid_valid", 64'(out_valid), 64'(0));
        check("rstmid_y", 64'(y), 64'(0));
        check("rstmid_rdy", 64'(in_ready), 64'(1));
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        check("rstmid_no_stale", 64'(out_valid), 64'(0));

        // Randomized traffic; the compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0), 1'($urandom), W'($urandom), W'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0);
            tick();
        end

        drive(1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
